// File: rtl/beta_pkg.sv
// beta_pkg: shared types and constants for the execute-stage multicycle sequencer
package beta_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_END, WRBACK, DRAIN} seq_state_t;
  localparam int SEQ_ERR_TIMEOUT = 0;
  localparam int SEQ_ERR_OVF = 1;
endpackage

// File: rtl/beta_seq_fifo.sv
// beta_seq_fifo: small FIFO with flush; a pop frees a slot for a same-cycle push when full
module beta_seq_fifo #(
  parameter int Width = 3,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(Depth - 1) ? '0 : p + AW'(1);
  endfunction
  assign empty_o = r_cnt == '0;
  assign full_o = r_cnt == CW'(Depth);
  assign w_pop = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);
  assign dout_o = r_mem[r_rp];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= w_push ? nxt(r_wp) : r_wp;
      r_rp <= w_pop ? nxt(r_rp) : r_rp;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) if (w_push && !flush_i) r_mem[r_wp] <= din_i;
endmodule

// File: rtl/beta_exe_mc_sequencer.sv
// beta_exe_mc_sequencer: execute-stage sequencer driving enable/busy handshakes of multicycle units
module beta_exe_mc_sequencer
  import beta_pkg::*;
#(
  parameter int NumUnits = 2,
  parameter int PendDepth = 2,
  parameter int StartTimeout = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                seq_new_instr_i,
  input  logic [NumUnits-1:0] seq_unit_sel_i,
  input  logic                seq_wr_en_i,
  input  logic                seq_trap_i,
  input  logic [NumUnits-1:0] seq_unit_busy_i,
  output logic [NumUnits-1:0] seq_unit_en_o,
  output logic [NumUnits-1:0] seq_cur_sel_o,
  output logic                seq_reg_wr_en_o,
  output logic                seq_busy_o,
  output logic                seq_pend_full_o,
  input  logic                seq_err_clr_i,
  output logic [1:0]          seq_err_o
);
  localparam int DW = NumUnits + 1;
  localparam int CW = $clog2(StartTimeout + 1);
  seq_state_t r_state;
  logic [NumUnits-1:0] r_sel;
  logic r_wr;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_err;
  logic [NumUnits-1:0] w_sel_pe;
  logic [DW-1:0] w_head, w_desc;
  logic w_idle, w_full, w_empty, w_push, w_pop, w_take, w_ovf, w_hit, w_tmo;
  logic [1:0] w_err_set;
  // isolate the lowest set select bit so only one unit is ever targeted
  assign w_sel_pe = seq_unit_sel_i & (~seq_unit_sel_i + NumUnits'(1));
  assign w_idle = r_state == IDLE;
  assign w_push = seq_new_instr_i & ~seq_trap_i & (~w_idle | ~w_empty);
  assign w_pop = w_idle & ~w_empty & ~seq_trap_i;
  assign w_take = w_idle & ~seq_trap_i & (~w_empty | seq_new_instr_i);
  assign w_ovf = w_push & w_full & ~w_pop;
  assign w_desc = w_empty ? {w_sel_pe, seq_wr_en_i} : w_head;
  assign w_hit = |(seq_unit_busy_i & r_sel);
  assign w_tmo = (r_state == ISSUE) & ~w_hit & ~seq_trap_i & (r_cnt == CW'(StartTimeout - 1));
  always_comb begin
    w_err_set = '0;
    w_err_set[SEQ_ERR_TIMEOUT] = w_tmo;
    w_err_set[SEQ_ERR_OVF] = w_ovf;
  end
  beta_seq_fifo #(.Width(DW), .Depth(PendDepth)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_push),
    .pop_i  (w_pop),
    .flush_i(seq_trap_i),
    .din_i  ({w_sel_pe, seq_wr_en_i}),
    .dout_o (w_head),
    .full_o (w_full),
    .empty_o(w_empty)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_sel <= '0;
      r_wr <= 1'b0;
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      r_err <= (seq_err_clr_i ? 2'b00 : r_err) | w_err_set;
      if (seq_trap_i) begin
        r_state <= DRAIN;
        r_sel <= '0;
        r_wr <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_take) begin
            r_sel <= w_desc[DW-1:1];
            r_wr <= w_desc[0];
            r_cnt <= '0;
            r_state <= |w_desc[DW-1:1] ? ISSUE : w_desc[0] ? WRBACK : IDLE;
          end
          ISSUE: begin
            r_cnt <= r_cnt + CW'(1);
            r_state <= w_hit ? WAIT_END : w_tmo ? IDLE : ISSUE;
          end
          WAIT_END: if (!w_hit) r_state <= r_wr ? WRBACK : IDLE;
          WRBACK: r_state <= IDLE;
          DRAIN: if (~|seq_unit_busy_i) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign seq_unit_en_o = (r_state == ISSUE && !seq_trap_i) ? r_sel : '0;
  assign seq_cur_sel_o = w_idle ? '0 : r_sel;
  assign seq_reg_wr_en_o = (r_state == WRBACK) & ~seq_trap_i;
  assign seq_busy_o = ~w_idle | ~w_empty;
  assign seq_pend_full_o = w_full;
  assign seq_err_o = r_err;
endmodule

// File: doc/beta_exe_mc_sequencer.md
Name: beta_exe_mc_sequencer

Overview:
- Parametrised execute-stage control unit for multicycle operations, sequencing up to NumUnits sequential functional units (shifter, LSU, future mul/div).
- Latches instruction requests into a pending queue while busy and runs an enable/busy handshake per unit.
- Produces a single-cycle register write strobe, aborts on trap, and flags start-timeout and queue-overflow errors.
- Sits between the decode-stage control word and the execute-stage operative units; replaces the per-unit hard-coded FSMs.

Parameters:
- NumUnits, 2, number of sequential units; unit i uses bit i of every NumUnits-wide port.
- PendDepth, 2, pending-instruction queue depth (power of two, >=1).
- StartTimeout, 8, max cycles in ISSUE waiting for the selected unit's busy to rise.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- seq_new_instr_i  in  1  one-cycle new-instruction pulse.
- seq_unit_sel_i  in  NumUnits  one-hot target unit; all-zero means single-cycle op.
- seq_wr_en_i  in  1  instruction writes the register file.
- seq_trap_i  in  1  trap/exception detected; aborts the current op.
- seq_unit_busy_i  in  NumUnits  per-unit busy.
- seq_unit_en_o  out  NumUnits  per-unit enable.
- seq_cur_sel_o  out  NumUnits  one-hot unit of the executing op, for result muxing.
- seq_reg_wr_en_o  out  1  one-cycle register write strobe.
- seq_busy_o  out  1  stage busy (stall decode).
- seq_pend_full_o  out  1  queue full.
- seq_err_clr_i  in  1  clears sticky errors.
- seq_err_o  out  2  sticky errors: [0] start timeout, [1] queue overflow.

Behaviour:
- Reset (async, active-high): state IDLE, queue empty, timeout counter 0. All outputs 0.
- Descriptor is {sel, wr_en}. If more than one sel bit is set, the lowest index wins (priority-encoded at capture).
- States: IDLE, ISSUE, WAIT_END, WRBACK, DRAIN.
- IDLE:
  - If the queue is non-empty, pop the head. Otherwise, if seq_new_instr_i is high, accept it directly.
  - Accepted descriptor with sel==0: go to WRBACK if wr_en, else stay in IDLE (retired).
  - Accepted descriptor with sel!=0: go to ISSUE and clear the timeout counter.
- ISSUE:
  - seq_unit_en_o[sel] is high.
  - On seq_unit_busy_i[sel]==1: go to WAIT_END; en drops that same edge.
  - Otherwise increment the counter. When it reaches StartTimeout, set seq_err_o[0] and go to IDLE with no write.
- WAIT_END: on seq_unit_busy_i[sel]==0, go to WRBACK if wr_en, else IDLE.
- WRBACK: seq_reg_wr_en_o high for exactly one cycle, then IDLE.
- Latency:
  - Single-cycle op with wr_en: strobe in cycle T+1 after acceptance in cycle T.
  - Multicycle op: strobe one cycle after busy falls.
- Queue:
  - seq_new_instr_i arriving outside IDLE, or in IDLE while the queue is non-empty, is pushed.
  - Simultaneous push and pop in IDLE is legal: the head is popped and the new entry pushed at the tail.
  - Push when full (with no same-cycle pop) drops the entry and sets seq_err_o[1].
  - Pointers wrap modulo PendDepth; seq_pend_full_o = count==PendDepth.
- seq_busy_o = (state != IDLE) | (count != 0), combinational.
- seq_cur_sel_o holds the sel of the executing op; 0 in IDLE.
- Trap:
  - seq_trap_i high in any cycle combinationally forces seq_unit_en_o=0 and seq_reg_wr_en_o=0.
  - The next state is DRAIN, the queue is flushed, and a coinciding seq_new_instr_i is dropped.
  - DRAIN waits until seq_unit_busy_i==0 (all units), then goes to IDLE. seq_busy_o is high in DRAIN.
  - A trap while in IDLE with an empty queue still flushes any coinciding instruction; go to DRAIN, which exits next cycle if no unit is busy.
- Errors are sticky; seq_err_clr_i clears them the next edge. A set and a clear in the same cycle resolve to set.
- Reset mid-operation returns to IDLE immediately and discards the queue; no strobe is produced.

Decomposition:
- beta_pkg: seq_state_t enum (IDLE, ISSUE, WAIT_END, WRBACK, DRAIN); constants SEQ_ERR_TIMEOUT=0 and SEQ_ERR_OVF=1.
- Sub-module beta_seq_fifo: parametrised width/depth FIFO with push/pop/flush, full/empty, and simultaneous push+pop support.
- The FSM and timeout counter live in the top module.

Test Plan:
- Single-cycle write: sel=00, wr_en=1 pulse at cycle 5 (idle) -> seq_reg_wr_en_o=1 at cycle 6 only; busy_o high at cycle 6 only.
- Multicycle: sel=01 at cycle 5; unit 0 busy rises at 8, falls at 15 -> en_o[0] high cycles 6-8; strobe at cycle 16; cur_sel=01 during 6-16.
- Queueing: issue sel=10 and, while busy, pulse two more ops (PendDepth=2) -> both execute in order; a third pulse while full sets err_o[1] and is never executed.
- Timeout: sel=01, busy never rises, StartTimeout=8 -> en_o[0] high 8 cycles, err_o[0]=1, no strobe, IDLE after; err_clr clears it.
- Trap in WAIT_END with 1 entry queued and busy still high 3 more cycles -> no strobe, queue empty, busy_o high until busy falls, then IDLE.
- Async reset asserted mid-ISSUE -> en_o=0 immediately without a clock edge, state IDLE, count 0.
